// File: rtl/rsc_stream_encoder.sv
// 8-state LTE RSC constituent encoder (g0=13, g1=15) with 3-step trellis termination.
// Emits a systematic then a parity antipodal soft sample per trellis step on one stream.
module rsc_stream_encoder #(
  parameter int AMP     = 1024,
  parameter int MAX_BLK = 6144
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [12:0]        blklen,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               sys_slot,
  output logic               sop,
  output logic               eop,
  output logic               busy,
  output logic               start_err
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, FLUSH} state_t;

  localparam logic signed [15:0] POS = 16'(AMP);
  localparam logic signed [15:0] NEG = 16'(-AMP);

  state_t      state, state_nxt;
  logic        s1, s2, s3;
  logic        s1_nxt, s2_nxt, s3_nxt;
  logic [12:0] cnt, cnt_nxt;
  logic [12:0] len, len_nxt;
  logic        phase, phase_nxt;
  logic [1:0]  tail_cnt, tail_nxt;
  logic        par, par_nxt;

  logic               valid_nxt;
  logic signed [15:0] out_nxt;
  logic               sys_nxt, sop_nxt, eop_nxt, err_nxt;

  logic slot_free;
  logic u, f, p;

  assign slot_free = !sample_valid || sample_ready;
  assign busy      = (state != IDLE);

  // During termination the input is chosen so that the feedback bit f is 0.
  assign u = (state == TAIL) ? (s2 ^ s3) : bit_in;
  assign f = u ^ s2 ^ s3;
  assign p = f ^ s1 ^ s3;

  always_comb begin
    state_nxt = state;
    s1_nxt    = s1;
    s2_nxt    = s2;
    s3_nxt    = s3;
    cnt_nxt   = cnt;
    len_nxt   = len;
    phase_nxt = phase;
    tail_nxt  = tail_cnt;
    par_nxt   = par;
    valid_nxt = slot_free ? 1'b0 : sample_valid;
    out_nxt   = sample_out;
    sys_nxt   = sys_slot;
    sop_nxt   = sop;
    eop_nxt   = eop;
    err_nxt   = 1'b0;
    bit_ready = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (blklen != '0 && blklen <= 13'(MAX_BLK)) begin
            len_nxt   = blklen;
            cnt_nxt   = '0;
            phase_nxt = 1'b0;
            s1_nxt    = 1'b0;
            s2_nxt    = 1'b0;
            s3_nxt    = 1'b0;
            state_nxt = DATA;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      DATA: begin
        if (!phase) begin
          bit_ready = slot_free;
          if (bit_valid && slot_free) begin
            valid_nxt = 1'b1;
            out_nxt   = u ? NEG : POS;
            sys_nxt   = 1'b1;
            sop_nxt   = (cnt == '0);
            eop_nxt   = 1'b0;
            par_nxt   = p;
            s1_nxt    = f;
            s2_nxt    = s1;
            s3_nxt    = s2;
            cnt_nxt   = cnt + 13'd1;
            phase_nxt = 1'b1;
          end
        end else if (slot_free) begin
          valid_nxt = 1'b1;
          out_nxt   = par ? NEG : POS;
          sys_nxt   = 1'b0;
          sop_nxt   = 1'b0;
          eop_nxt   = 1'b0;
          phase_nxt = 1'b0;
          if (cnt == len) begin
            state_nxt = TAIL;
            tail_nxt  = '0;
          end
        end
      end

      TAIL: begin
        if (slot_free) begin
          valid_nxt = 1'b1;
          sop_nxt   = 1'b0;
          if (!phase) begin
            out_nxt   = u ? NEG : POS;
            sys_nxt   = 1'b1;
            eop_nxt   = 1'b0;
            par_nxt   = p;
            s1_nxt    = f;
            s2_nxt    = s1;
            s3_nxt    = s2;
            phase_nxt = 1'b1;
          end else begin
            out_nxt   = par ? NEG : POS;
            sys_nxt   = 1'b0;
            eop_nxt   = (tail_cnt == 2'd2);
            phase_nxt = 1'b0;
            tail_nxt  = tail_cnt + 2'd1;
            if (tail_cnt == 2'd2) state_nxt = FLUSH;
          end
        end
      end

      FLUSH: begin
        if (slot_free) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      cnt          <= '0;
      len          <= '0;
      phase        <= 1'b0;
      tail_cnt     <= '0;
      par          <= 1'b0;
      sample_valid <= 1'b0;
      sample_out   <= '0;
      sys_slot     <= 1'b0;
      sop          <= 1'b0;
      eop          <= 1'b0;
      start_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      s1           <= s1_nxt;
      s2           <= s2_nxt;
      s3           <= s3_nxt;
      cnt          <= cnt_nxt;
      len          <= len_nxt;
      phase        <= phase_nxt;
      tail_cnt     <= tail_nxt;
      par          <= par_nxt;
      sample_valid <= valid_nxt;
      sample_out   <= out_nxt;
      sys_slot     <= sys_nxt;
      sop          <= sop_nxt;
      eop          <= eop_nxt;
      start_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_rsc_stream_encoder.sv
// Scoreboard bench for rsc_stream_encoder: directed blocks push expected samples,
// a negedge monitor pops and compares every accepted output sample.
module tb_rsc_stream_encoder;

  logic               clk;
  logic               rst;
  logic               start;
  logic [12:0]        blklen;
  logic               bit_in;
  logic               bit_valid;
  logic               bit_ready;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               sample_ready;
  logic               sys_slot;
  logic               sop;
  logic               eop;
  logic               busy;
  logic               start_err;

  rsc_stream_encoder #(.AMP(1024), .MAX_BLK(6144)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .blklen       (blklen),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sys_slot     (sys_slot),
    .sop          (sop),
    .eop          (eop),
    .busy         (busy),
    .start_err    (start_err)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        sys;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic bp_mode = 1'b0;

  // Hand-computed stream for blklen=4, bits 1,0,0,0.
  int exp4[14] = '{-1024, -1024, 1024, -1024, 1024, -1024, 1024, -1024,
                   -1024, -1024, 1024, -1024, -1024, -1024};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endfunction

  task automatic push_exp(input int idx, input int total, input int val);
    exp_t e;
    e.s   = 16'(val);
    e.sys = (idx % 2 == 0);
    e.sop = (idx == 0);
    e.eop = (idx == total - 1);
    exp_q.push_back(e);
  endtask

  task automatic push_blk4();
    for (int i = 0; i < 14; i++) push_exp(i, 14, exp4[i]);
  endtask

  task automatic push_zeros(input int len);
    for (int i = 0; i < 2 * (len + 3); i++) push_exp(i, 2 * (len + 3), 1024);
  endtask

  // sample_ready pattern 1,0,0,1 repeating while bp_mode is set
  initial begin
    logic [3:0] pat;
    int unsigned bp_idx;
    pat = 4'b1001;
    bp_idx = 0;
    sample_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        sample_ready = pat[bp_idx];
        bp_idx = (bp_idx + 1) % 4;
      end else begin
        sample_ready = 1'b1;
        bp_idx = 0;
      end
    end
  end

  // Monitor
  initial begin
    logic        held;
    logic [18:0] held_v;
    logic        idle_chk;
    exp_t        e;
    exp_t        got;
    held = 1'b0;
    held_v = '0;
    idle_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        held = 1'b0;
        idle_chk = 1'b0;
      end else begin
        if (idle_chk) begin
          chk("busy_after_eop", {31'd0, busy}, 32'd0);
          idle_chk = 1'b0;
        end
        if (sample_valid) begin
          got = '{s: sample_out, sys: sys_slot, sop: sop, eop: eop};
          if (held) chk("held_stable", {13'd0, got}, {13'd0, held_v});
          if (sys_slot) chk("no_bit_while_par_pending", {31'd0, bit_ready}, 32'd0);
          if (sample_ready) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_sample", {13'd0, got}, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("sample", {13'd0, got}, {13'd0, e});
            end
            held = 1'b0;
            if (eop) idle_chk = 1'b1;
          end else begin
            held = 1'b1;
            held_v = got;
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  task automatic send_block(input int len, input int nsend, input logic [63:0] bits,
                            input logic busy_start);
    int  waited;
    logic got;
    start = 1'b1;
    blklen = 13'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      bit_valid = 1'b1;
      bit_in = bits[i];
      waited = 0;
      got = 1'b0;
      while (!got && waited < 200) begin
        @(negedge clk);
        if (bit_ready) got = 1'b1;
        else waited++;
      end
      if (!got) chk("bit_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      if (busy_start && i == 1) begin
        start = 1'b1;
        blklen = 13'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start_no_err", {31'd0, start_err}, 32'd0);
        chk("busy_start_still_busy", {31'd0, busy}, 32'd1);
      end
    end
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic bad_start(input int len, input string name);
    start = 1'b1;
    blklen = 13'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk(name, {31'd0, start_err}, 32'd1);
    chk("bad_start_not_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("start_err_one_cycle", {31'd0, start_err}, 32'd0);
    chk("bad_start_no_sample", {31'd0, sample_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    blklen = '0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_outputs",
        {15'd0, sample_out, sample_valid, bit_ready, sop, eop, busy, start_err, sys_slot},
        32'd0);

    // Basic 4-bit block
    @(posedge clk);
    #1;
    push_blk4();
    send_block(4, 4, 64'b0001, 1'b0);
    wait_drain("blk4_drain");

    // 40 zero bits
    push_zeros(40);
    send_block(40, 40, 64'd0, 1'b0);
    wait_drain("zeros40_drain");

    // Backpressure
    bp_mode = 1'b1;
    push_blk4();
    send_block(4, 4, 64'b0001, 1'b0);
    wait_drain("blk4_bp_drain");
    bp_mode = 1'b0;
    @(posedge clk);
    #1;

    // Rejected starts
    bad_start(0, "start_err_len0");
    bad_start(6145, "start_err_len6145");

    // Start while busy is ignored
    push_blk4();
    send_block(4, 4, 64'b0001, 1'b1);
    wait_drain("blk4_busy_start_drain");

    // Reset mid-block
    push_zeros(40);
    send_block(40, 5, 64'd0, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midreset_valid", {31'd0, sample_valid}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_blk4();
    send_block(4, 4, 64'b0001, 1'b0);
    wait_drain("blk4_after_reset_drain");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rsc_stream_encoder.md
Name: rsc_stream_encoder

Overview:
- 8-state LTE RSC constituent encoder (g0=13, g1=15 octal) with 3-step trellis termination.
- Serialises each step as a systematic sample then a parity sample, as signed 16-bit antipodal soft values, into the single-stream format the SISO decoder top consumes.
- Also drives a systematic-slot flag marking the sample positions that pair with apriori in that stream.
- Sits upstream of the decoder as the stimulus/transmit end: it generates the channel stream the decoder receives.

Parameters:
- AMP, 1024, magnitude of output samples: bit 0 -> +AMP, bit 1 -> -AMP; legal range 1..32767.
- MAX_BLK, 6144, largest accepted blklen.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- start  in  1  one-cycle pulse; latches blklen and begins a block.
- blklen  in  13  information bits per block; sampled only on an accepted start.
- bit_in  in  1  information bit.
- bit_valid  in  1  bit_in valid.
- bit_ready  out  1  encoder accepts bit_in this cycle.
- sample_out  out  16  signed soft sample.
- sample_valid  out  1  sample_out valid.
- sample_ready  in  1  downstream accepts sample_out.
- sys_slot  out  1  1 = current sample is systematic, 0 = parity; qualified by sample_valid.
- sop  out  1  first sample of block; qualified by sample_valid.
- eop  out  1  last tail parity sample; qualified by sample_valid.
- busy  out  1  block in progress.
- start_err  out  1  one-cycle pulse: start rejected.

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, trellis regs s1=s2=s3=0, bit counter=0, phase=0. Outputs: sample_valid, bit_ready, sop, eop, busy, start_err = 0; sample_out=0; sys_slot=0.
- Reset mid-block aborts the block immediately. No partial output after the reset edge.
- Output register rule: slot_free = !sample_valid || sample_ready. A sample held while sample_ready=0 keeps sample_out, sys_slot, sop and eop stable.
- States: IDLE, DATA, TAIL, FLUSH.
- IDLE, start=1 with 1<=blklen<=MAX_BLK: latch blklen, counter=0, phase=0, busy=1, go DATA.
- IDLE, start=1 with blklen=0 or blklen>MAX_BLK: start_err=1 for one cycle, stay IDLE.
- start while busy=1 is ignored, with no start_err.
- Step equations: f = u^s2^s3; p = f^s1^s3; next (s1,s2,s3) = (f,s1,s2).
- DATA, phase=0: bit_ready = slot_free (combinational). On bit_valid&&bit_ready:
  - register systematic sample for u=bit_in, sys_slot=1, sop=(counter==0);
  - hold p internally, update trellis regs, counter++, phase=1.
  - Latency: sample_valid rises the cycle after the accept.
- DATA, phase=1: bit_ready=0. When slot_free, register parity sample, sys_slot=0, phase=0. If counter==blklen, go TAIL with tail count=0.
- TAIL, 3 steps, no input, bit_ready=0:
  - u = s2^s3 (forces f=0); systematic = u, parity = s1^s3.
  - Each sample waits on slot_free, same two-phase order as DATA.
  - The third step's parity sample has eop=1. Trellis is 000 after step 3.
- FLUSH: wait until the eop sample is accepted (slot_free), then busy=0 and go IDLE.
- A new start is honoured in the same cycle busy drops.
- Block output is exactly 2*(blklen+3) samples, strictly alternating sys/par, beginning with sys.
- sample_out is never given a value other than +AMP or -AMP while sample_valid=1.

Test Plan:
- Reset then idle: hold rst=0 for 10 cycles, release -> all outputs 0, bit_ready=0, busy=0.
- blklen=4, bits 1,0,0,0, sample_ready=1, AMP=1024 -> 14 samples: -1024,-1024, +1024,-1024, +1024,-1024, +1024,-1024, -1024,-1024, +1024,-1024, -1024,-1024. sys_slot alternates 1,0; sop on sample 1, eop on sample 14; trellis 000 at end.
- blklen=40, all-zero bits -> 86 samples, all +1024; busy deasserts one cycle after the eop sample is accepted.
- Backpressure: repeat the blklen=4 case with sample_ready toggling 1,0,0,1,… -> identical 14-value sequence, each held sample stable while stalled, no bit accepted while the parity slot is pending.
- Bad start: blklen=0, then blklen=6145 -> start_err pulses once each, busy stays 0. start while busy -> ignored and the block completes unaltered.
- Reset mid-block: rst=0 after 5 bits of a 40-bit block -> next cycle sample_valid=0, busy=0. A fresh blklen=4 block then reproduces the 14-sample sequence exactly.
